// File: rtl/siso_pkg.sv
// ---------------------------------------------------------------------------
// siso_pkg
// Shared definitions for the SISO decoder input path: LLR type, legal
// block-length range, default widths and the framer state encoding.
// Imported by the LLR framer and by the decoder top.
// ---------------------------------------------------------------------------
package siso_pkg;

    localparam int LLR_W   = 16;    // width of every LLR field
    localparam int BLK_W   = 16;    // width of the block-length field
    localparam int BLK_MIN = 40;    // smallest legal block length
    localparam int BLK_MAX = 6144;  // largest legal block length
    localparam int CFG_GAP = 2;     // idle cycles between config pulse and first SYS

    typedef logic signed [LLR_W-1:0] llr_t;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        GAP,
        SYS,
        PAR,
        DONE
    } framer_state_t;

endpackage

// File: rtl/siso_llr_framer.sv
// ---------------------------------------------------------------------------
// siso_llr_framer
// Source end of the SISO decoder input interface. Accepts one upstream word
// per trellis step (systematic, parity, a-priori LLR) and emits the decoder
// protocol: a one-cycle block-length config pulse, a fixed idle gap, then
// two cycles per step -- SYS (in=sys, apriori=apr, valid_apriori=1) followed
// by PAR (in=par, valid_apriori=0). One frame at a time.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, start_blklen        1-cycle frame request and its block length
//   s_valid/s_ready            upstream handshake, s_sys/s_par/s_apr payload
//   blklen, valid_blklen       block length (held for the frame), config pulse
//   in, valid_in               LLR stream to the decoder
//   apriori, valid_apriori     a-priori LLR, valid only on SYS cycles
//   busy, done, err            frame in progress, end-of-frame pulse,
//                              illegal-length pulse
// ---------------------------------------------------------------------------
module siso_llr_framer #(
    parameter int LLR_W   = siso_pkg::LLR_W,
    parameter int BLK_W   = siso_pkg::BLK_W,
    parameter int BLK_MIN = siso_pkg::BLK_MIN,
    parameter int BLK_MAX = siso_pkg::BLK_MAX,
    parameter int CFG_GAP = siso_pkg::CFG_GAP
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic        [BLK_W-1:0] start_blklen,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [LLR_W-1:0] s_sys,
    input  logic signed [LLR_W-1:0] s_par,
    input  logic signed [LLR_W-1:0] s_apr,
    output logic        [BLK_W-1:0] blklen,
    output logic                    valid_blklen,
    output logic signed [LLR_W-1:0] in,
    output logic                    valid_in,
    output logic signed [LLR_W-1:0] apriori,
    output logic                    valid_apriori,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    import siso_pkg::*;

    // Gap counter runs 0 .. CFG_GAP-1.
    localparam int               GAP_W    = (CFG_GAP > 1) ? $clog2(CFG_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CFG_GAP - 1);

    framer_state_t            state;
    logic         [GAP_W-1:0] gap_cnt;
    logic         [BLK_W-1:0] step_cnt;
    logic         [BLK_W-1:0] step_next;
    logic signed  [LLR_W-1:0] par_hold;
    logic                     len_ok;

    assign len_ok    = (start_blklen >= BLK_W'(BLK_MIN)) &&
                       (start_blklen <= BLK_W'(BLK_MAX));
    assign step_next = step_cnt + BLK_W'(1);

    // blklen doubles as the frame-length register: it is latched on start and
    // held until the frame returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            step_cnt      <= '0;
            // NOTE: the PAR hold register is cleared on reset as well, so a
            // dropped frame can never leak its last parity word into the next.
            par_hold      <= '0;
            s_ready       <= 1'b0;
            blklen        <= '0;
            valid_blklen  <= 1'b0;
            in            <= '0;
            valid_in      <= 1'b0;
            apriori       <= '0;
            valid_apriori <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; pulse outputs get a
            // default here and are raised only by the state that owns them.
            valid_blklen <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            blklen       <= start_blklen;
                            valid_blklen <= 1'b1;
                            step_cnt     <= '0;
                            busy         <= 1'b1;
                            state        <= CFG;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                CFG: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        s_ready <= 1'b1;
                        state   <= SYS;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                SYS: begin
                    if (s_valid && s_ready) begin
                        in            <= s_sys;
                        apriori       <= s_apr;
                        valid_in      <= 1'b1;
                        valid_apriori <= 1'b1;
                        par_hold      <= s_par;
                        s_ready       <= 1'b0;
                        state         <= PAR;
                    end else begin
                        // Bubble: in/apriori keep their last values.
                        valid_in      <= 1'b0;
                        valid_apriori <= 1'b0;
                    end
                end

                // PAR never waits: the decoder cannot apply backpressure.
                PAR: begin
                    in            <= par_hold;
                    valid_in      <= 1'b1;
                    valid_apriori <= 1'b0;
                    step_cnt      <= step_next;
                    if (step_next == blklen) begin
                        state <= DONE;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= SYS;
                    end
                end

                DONE: begin
                    valid_in <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    blklen   <= '0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_siso_llr_framer.sv
// ---------------------------------------------------------------------------
// tb_siso_llr_framer
// Directed bench for siso_llr_framer. Each frame's expected decoder stream
// (sys0,par0,sys1,par1,... with a-priori held across each step) is built up
// front from the stimulus tables; a monitor pops it on every valid_in cycle
// and also tracks config/gap/done timing and handshake counts per frame.
// ---------------------------------------------------------------------------
module tb_siso_llr_framer;

    import siso_pkg::*;

    localparam int MAXLEN = 6144;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] start_blklen;
    logic        s_valid;
    logic        s_ready;
    llr_t        s_sys;
    llr_t        s_par;
    llr_t        s_apr;
    logic [15:0] blklen;
    logic        valid_blklen;
    logic [15:0] llr_in;
    logic        valid_in;
    logic [15:0] apriori;
    logic        valid_apriori;
    logic        busy;
    logic        done;
    logic        err;

    siso_llr_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_blklen  (start_blklen),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_sys         (s_sys),
        .s_par         (s_par),
        .s_apr         (s_apr),
        .blklen        (blklen),
        .valid_blklen  (valid_blklen),
        .in            (llr_in),
        .valid_in      (valid_in),
        .apriori       (apriori),
        .valid_apriori (valid_apriori),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [15:0] v;
        logic        va;
        logic [15:0] apr;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] sys_a[MAXLEN];
    logic [15:0] par_a[MAXLEN];
    logic [15:0] apr_a[MAXLEN];
    int          exp_len;

    task automatic load_frame(input int len, input int seed, input bit sign);
        exp_t e;
        exp_q.delete();
        for (int k = 0; k < len; k++) begin
            sys_a[k] = 16'(k * 293 + seed * 7);
            par_a[k] = 16'((k * 1021) ^ seed);
            apr_a[k] = 16'(32'hF000 + k * 3 + seed);
        end
        if (sign) begin
            sys_a[0] = 16'h8000;
            par_a[0] = 16'h7FFF;
            apr_a[0] = 16'hFFFF;
        end
        for (int k = 0; k < len; k++) begin
            e.v = sys_a[k]; e.va = 1'b1; e.apr = apr_a[k];
            exp_q.push_back(e);
            e.v = par_a[k]; e.va = 1'b0; e.apr = apr_a[k];
            exp_q.push_back(e);
        end
        exp_len = len;
    endtask

    // ---------------- per-frame statistics ----------------
    int          cyc_cnt = 0;
    int          n_vb, vb_cycle, first_ready, n_vi, first_vi, last_vi;
    int          n_done, done_cycle, n_hs, n_err;
    bit          busy_seen;
    bit          prev_va = 1'b0;
    logic [15:0] cap_in0, cap_in1, cap_apr0;

    task automatic clear_stats();
        n_vb = 0; vb_cycle = -1; first_ready = -1; n_vi = 0; first_vi = -1; last_vi = -1;
        n_done = 0; done_cycle = -1; n_hs = 0; n_err = 0; busy_seen = 1'b0;
        cap_in0 = '0; cap_in1 = '0; cap_apr0 = '0;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        clear_stats();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_va = 1'b0;
            end else begin
                cyc_cnt++;
                if (valid_blklen) begin
                    n_vb++;
                    vb_cycle = cyc_cnt;
                    check("cfg_blklen", blklen, exp_len);
                end
                if (err) n_err++;
                if (busy) busy_seen = 1'b1;
                if (done) begin
                    n_done++;
                    done_cycle = cyc_cnt;
                end
                if (s_ready && first_ready < 0) first_ready = cyc_cnt;
                if (s_valid && s_ready) n_hs++;
                check("ready_implies_busy", s_ready && !busy, 0);
                if (prev_va) check("par_follows_sys", valid_in, 1);
                if (valid_in) begin
                    check("stream_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("in", llr_in, e.v);
                        check("valid_apriori", valid_apriori, e.va);
                        check("apriori", apriori, e.apr);
                        check("blklen_held", blklen, exp_len);
                    end
                    if (n_vi == 0) begin
                        cap_in0  = llr_in;
                        cap_apr0 = apriori;
                    end
                    if (n_vi == 1) cap_in1 = llr_in;
                    n_vi++;
                    if (first_vi < 0) first_vi = cyc_cnt;
                    last_vi = cyc_cnt;
                end else begin
                    check("va_without_vi", valid_apriori, 0);
                end
                prev_va = valid_in && valid_apriori;
            end
        end
    end

    // ---------------- drivers ----------------
    // Called just after a rising edge. mode 1 drops s_valid on every third
    // cycle that s_ready is offered. spur_at/rst_at: step index at which a
    // stray start is pulsed / at which the run stops for a reset (-1 = never).
    task automatic run_frame(input int len, input int mode, input int spur_at,
                             input int rst_at, output bit aborted);
        int idx = 0;
        int opp = 0;
        int cyc = 0;
        bit took;
        bit spur_done = 1'b0;
        aborted      = 1'b0;
        start        = 1'b1;
        start_blklen = 16'(len);
        @(posedge clk); #1;
        start = 1'b0;
        while (n_done == 0 && cyc < 4 * len + 64) begin
            if (rst_at >= 0 && idx == rst_at) begin
                aborted = 1'b1;
                break;
            end
            if (spur_at >= 0 && idx == spur_at && !spur_done) begin
                start        = 1'b1;
                start_blklen = 16'd39;
                spur_done    = 1'b1;
            end
            if (idx >= len) begin
                s_valid = 1'b0;
            end else if (mode == 1 && s_ready) begin
                opp++;
                s_valid = (opp % 3) != 0;
            end else begin
                s_valid = 1'b1;
            end
            s_sys = (idx < len) ? sys_a[idx] : 16'h0;
            s_par = (idx < len) ? par_a[idx] : 16'h0;
            s_apr = (idx < len) ? apr_a[idx] : 16'h0;
            @(negedge clk);
            took = s_valid && s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (took) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        if (!aborted) check("frame_done_in_budget", n_done > 0, 1);
    endtask

    task automatic try_illegal(input int len);
        clear_stats();
        start        = 1'b1;
        start_blklen = 16'(len);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("illegal_err_pulse", n_err, 1);
        check("illegal_no_cfg", n_vb, 0);
        check("illegal_not_busy", busy_seen, 0);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("done_single_pulse", n_done, 1);
        check("model_drained", exp_q.size(), 0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        bit aborted;
        rst_n = 1'b0; start = 1'b0; start_blklen = '0; s_valid = 1'b0;
        s_sys = '0; s_par = '0; s_apr = '0; exp_len = 0;
        #12;
        check("rst_s_ready", s_ready, 0);
        check("rst_valid_blklen", valid_blklen, 0);
        check("rst_blklen", blklen, 0);
        check("rst_valid_in", valid_in, 0);
        check("rst_in", llr_in, 0);
        check("rst_apriori", apriori, 0);
        check("rst_valid_apriori", valid_apriori, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 40-step frame, upstream always valid.
        load_frame(40, 1, 1'b0);
        clear_stats();
        run_frame(40, 0, -1, -1, aborted);
        settle();
        check("t1_one_cfg", n_vb, 1);
        check("t1_gap", first_ready - vb_cycle, siso_pkg::CFG_GAP + 1);
        check("t1_valid_in_count", n_vi, 80);
        check("t1_continuous", last_vi - first_vi + 1, 80);
        check("t1_done_timing", done_cycle, last_vi + 1);
        check("t1_handshakes", n_hs, 40);
        check("t1_pin_sys0", cap_in0, 16'h0007);
        check("t1_pin_par0", cap_in1, 16'h0001);

        // 512 steps with every third SYS opportunity bubbled.
        load_frame(512, 2, 1'b0);
        clear_stats();
        run_frame(512, 1, -1, -1, aborted);
        settle();
        check("t2_valid_in_count", n_vi, 1024);
        check("t2_handshakes", n_hs, 512);
        check("t2_bubbles_present", n_vi < (last_vi - first_vi + 1), 1);

        // Length limits.
        try_illegal(39);
        try_illegal(6145);
        load_frame(6144, 3, 1'b0);
        clear_stats();
        run_frame(6144, 0, -1, -1, aborted);
        settle();
        check("t3_max_cfg", n_vb, 1);
        check("t3_max_valid_in", n_vi, 12288);
        check("t3_max_no_err", n_err, 0);

        // Stray (illegal-length) start in mid-frame must be ignored.
        load_frame(40, 4, 1'b0);
        clear_stats();
        run_frame(40, 0, 10, -1, aborted);
        settle();
        check("t4_no_err", n_err, 0);
        check("t4_one_cfg", n_vb, 1);
        check("t4_valid_in_count", n_vi, 80);

        // Reset in the middle of a 512-step frame.
        load_frame(512, 5, 1'b0);
        clear_stats();
        run_frame(512, 0, -1, 20, aborted);
        check("t5_reached_step20", aborted, 1);
        check("t5_busy_before_rst", busy, 1);
        check("t5_valid_in_before_rst", valid_in, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_valid_in", valid_in, 0);
        check("t5_rst_in", llr_in, 0);
        check("t5_rst_apriori", apriori, 0);
        check("t5_rst_blklen", blklen, 0);
        check("t5_rst_s_ready", s_ready, 0);
        repeat (3) @(posedge clk);
        check("t5_no_done", n_done, 0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        load_frame(40, 6, 1'b0);
        clear_stats();
        run_frame(40, 0, -1, -1, aborted);
        settle();
        check("t5_clean_sys0", cap_in0, 16'h002A);
        check("t5_clean_count", n_vi, 80);

        // Bit-exact extremes.
        load_frame(40, 7, 1'b1);
        clear_stats();
        run_frame(40, 0, -1, -1, aborted);
        settle();
        check("t6_sys_8000", cap_in0, 16'h8000);
        check("t6_par_7fff", cap_in1, 16'h7FFF);
        check("t6_apr_ffff", cap_apr0, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
